// File: rtl/uni_pkg.sv
// Shared types and codes for the unified bus arbiter and its requester ports.
package uni_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/uni_if.sv
// Unified request/complete handshake: request fields held until the ready cycle,
// rdata/resp valid only in that cycle.
interface uni_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic              valid;
   logic              ready;
   logic              reqtyp;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        size;
   logic [1:0]        resp;

   modport Master (output valid, reqtyp, addr, wdata, size,
                   input  ready, rdata, resp);
   modport Slave  (input  valid, reqtyp, addr, wdata, size,
                   output ready, rdata, resp);
endinterface

// File: rtl/uni_arb_pick.sv
// Combinational 2-way picker: lone requester wins; on a tie either round-robin
// against the last grant or fixed priority to requester 1.
module uni_arb_pick (
   input  logic [1:0] req,
   input  logic       lg,
   input  logic       rr_en,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (&req) gnt = (rr_en && lg) ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/uni_bus_arb.sv
// Shares one downstream uni_if port between IFU (m0) and LSU (m1); grant held
// for the whole transaction, optional watchdog aborts stuck transfers.
module uni_bus_arb
   import uni_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter bit RR_EN  = 1'b1,
   parameter int TMO_W  = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   uni_if.Slave       m0,
   uni_if.Slave       m1,
   uni_if.Master      s,
   output logic [1:0] o_owner,
   output logic       o_tmo
);

   localparam int CNT_W = (TMO_W > 0) ? TMO_W : 1;

   arb_state_e        state_q, state_d;
   logic              lg_q, lg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        owner_q, owner_d;

   logic [1:0]        gnt;
   logic              busy, sel, sel_valid, abort, done;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   uni_arb_pick u_pick (
      .req   ({m1.valid, m0.valid}),
      .lg    (lg_q),
      .rr_en (RR_EN),
      .gnt   (gnt)
   );

   assign busy      = (state_q != IDLE);
   assign sel       = (state_q == GNT1);
   assign sel_valid = sel ? m1.valid : m0.valid;
   // Watchdog fires in the cycle the counter sits at all-ones; s.valid is already masked then.
   assign abort     = (TMO_W > 0) && busy && sel_valid && (cnt_q == '1);
   assign done      = busy && sel_valid && !abort && s.ready;
   assign sel_addr  = sel ? m1.addr  : m0.addr;
   assign sel_wdata = sel ? m1.wdata : m0.wdata;

   always_comb begin
      state_d = state_q;
      lg_d    = lg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (|gnt) begin
               state_d = gnt[1] ? GNT1 : GNT0;
               lg_d    = gnt[1];
               cnt_d   = '0;
            end
         end
         default: begin
            // Completion, abort or a requester dropping valid all release the bus.
            if (!sel_valid || abort || done) state_d = IDLE;
            else if (TMO_W > 0)              cnt_d   = cnt_q + CNT_W'(1);
         end
      endcase
      owner_d = {state_d == GNT1, state_d == GNT0};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         lg_q    <= 1'b1;
         cnt_q   <= '0;
         owner_q <= 2'b00;
      end else begin
         state_q <= state_d;
         lg_q    <= lg_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      s.valid  = busy && sel_valid && !abort;
      s.reqtyp = busy && (sel ? m1.reqtyp : m0.reqtyp);
      s.addr   = busy ? sel_addr  : '0;
      s.wdata  = busy ? sel_wdata : '0;
      s.size   = busy ? (sel ? m1.size : m0.size) : SZ_B;
      m0.ready = 1'b0;
      m0.rdata = '0;
      m0.resp  = RESP_OKAY;
      m1.ready = 1'b0;
      m1.rdata = '0;
      m1.resp  = RESP_OKAY;
      if (state_q == GNT0) begin
         m0.ready = abort | s.ready;
         m0.rdata = abort ? '0 : s.rdata;
         m0.resp  = abort ? RESP_SLVERR : s.resp;
      end
      if (state_q == GNT1) begin
         m1.ready = abort | s.ready;
         m1.rdata = abort ? '0 : s.rdata;
         m1.resp  = abort ? RESP_SLVERR : s.resp;
      end
   end

   assign o_owner = owner_q;
   assign o_tmo   = abort;

endmodule

// File: tb/tb_uni_bus_arb.sv
// Bench for uni_bus_arb: picker vector table, directed sequences and random
// traffic against a transaction-level model, on two configurations sharing stimulus.
module tb_uni_bus_arb;
   import uni_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]  m_valid, m_reqtyp;
   logic [31:0] m_addr[2];
   logic [63:0] m_wdata[2];
   logic [1:0]  m_size[2];
   logic        s_ready;
   logic [63:0] s_rdata;
   logic [1:0]  s_resp;

   // d=0: RR_EN=1, TMO_W=4   d=1: RR_EN=0, watchdog off
   logic [1:0]  d_owner[2];
   logic        d_tmo[2], d_sval[2], d_styp[2];
   logic [31:0] d_saddr[2];
   logic [63:0] d_swdata[2];
   logic [1:0]  d_ssize[2], d_mrdy[2];
   logic [63:0] d_mrdata[2][2];
   logic [1:0]  d_mresp[2][2];

   for (genvar d = 0; d < 2; d++) begin : g_dut
      uni_if #(.ADDR_W(32), .DATA_W(64)) m0_if(), m1_if(), s_if();
      assign m0_if.valid  = m_valid[0];
      assign m0_if.reqtyp = m_reqtyp[0];
      assign m0_if.addr   = m_addr[0];
      assign m0_if.wdata  = m_wdata[0];
      assign m0_if.size   = m_size[0];
      assign m1_if.valid  = m_valid[1];
      assign m1_if.reqtyp = m_reqtyp[1];
      assign m1_if.addr   = m_addr[1];
      assign m1_if.wdata  = m_wdata[1];
      assign m1_if.size   = m_size[1];
      assign s_if.ready   = s_ready;
      assign s_if.rdata   = s_rdata;
      assign s_if.resp    = s_resp;

      uni_bus_arb #(.ADDR_W(32), .DATA_W(64), .RR_EN(d == 0), .TMO_W(d == 0 ? 4 : 0)) dut (
         .i_clk(clk), .i_rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if),
         .o_owner(d_owner[d]), .o_tmo(d_tmo[d])
      );

      assign d_sval[d]      = s_if.valid;
      assign d_styp[d]      = s_if.reqtyp;
      assign d_saddr[d]     = s_if.addr;
      assign d_swdata[d]    = s_if.wdata;
      assign d_ssize[d]     = s_if.size;
      assign d_mrdy[d]      = {m1_if.ready, m0_if.ready};
      assign d_mrdata[d][0] = m0_if.rdata;
      assign d_mrdata[d][1] = m1_if.rdata;
      assign d_mresp[d][0]  = m0_if.resp;
      assign d_mresp[d][1]  = m1_if.resp;
   end

   logic [1:0] p_req, p_gnt;
   logic       p_lg, p_rr;
   uni_arb_pick u_pick (.req(p_req), .lg(p_lg), .rr_en(p_rr), .gnt(p_gnt));

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Transaction-level model: owner index (-1 idle), last winner, cycles waited.
   int own[2];
   bit lg[2];
   int cnt[2];
   bit chk_en = 1'b0;

   function automatic bit m_abort(input int d);
      if (d != 0 || own[d] < 0) return 1'b0;
      return m_valid[own[d]] && cnt[d] == 15;
   endfunction

   task automatic check_model(input int d);
      int          o;
      bit          ab;
      string       p;
      logic [1:0]  e_rdy;
      logic [63:0] e_rd[2];
      logic [1:0]  e_rs[2];
      o = own[d];
      ab = m_abort(d);
      p = (d == 0) ? "A" : "B";
      e_rdy = 2'b00;
      e_rd[0] = 0; e_rd[1] = 0;
      e_rs[0] = 0; e_rs[1] = 0;
      if (o < 0) begin
         chk({p, " owner"}, d_owner[d], 0);
         chk({p, " s.valid"}, d_sval[d], 0);
         chk({p, " s.fields"}, {d_styp[d], d_ssize[d], d_saddr[d]}, 0);
         chk({p, " s.wdata"}, d_swdata[d], 0);
      end else begin
         chk({p, " owner"}, d_owner[d], 1 << o);
         chk({p, " s.valid"}, d_sval[d], m_valid[o] && !ab);
         chk({p, " s.fields"}, {d_styp[d], d_ssize[d], d_saddr[d]},
             {m_reqtyp[o], m_size[o], m_addr[o]});
         chk({p, " s.wdata"}, d_swdata[d], m_wdata[o]);
         e_rdy[o] = ab | s_ready;
         e_rd[o]  = ab ? 64'h0 : s_rdata;
         e_rs[o]  = ab ? RESP_SLVERR : s_resp;
      end
      chk({p, " tmo"}, d_tmo[d], ab);
      chk({p, " m.ready"}, d_mrdy[d], e_rdy);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s m%0d.rdata", p, i), d_mrdata[d][i], e_rd[i]);
         chk($sformatf("%s m%0d.resp", p, i), d_mresp[d][i], e_rs[i]);
      end
   endtask

   task automatic model_step(input int d);
      int w;
      if (rst) begin
         own[d] = -1; lg[d] = 1'b1; cnt[d] = 0;
      end else if (own[d] < 0) begin
         if (m_valid != 2'b00) begin
            if (m_valid == 2'b11) w = (d == 0) ? (lg[d] ? 0 : 1) : 1;
            else w = m_valid[1] ? 1 : 0;
            own[d] = w; lg[d] = (w == 1); cnt[d] = 0;
         end
      end else if (!m_valid[own[d]] || m_abort(d) || s_ready) begin
         own[d] = -1;
      end else begin
         cnt[d]++;
      end
   endtask

   always @(negedge clk) if (chk_en) for (int d = 0; d < 2; d++) check_model(d);
   always @(posedge clk) for (int d = 0; d < 2; d++) model_step(d);

   task automatic cyc();
      @(posedge clk); #1;
   endtask
   task automatic mid();
      @(negedge clk); #1;
   endtask

   typedef struct {
      logic [1:0] req;
      logic       lg;
      logic       rr;
      logic [1:0] gnt;
   } pick_vec_t;

   pick_vec_t  tbl[10];
   logic [1:0] exp_a[8], exp_b[8];
   int         thr;

   initial begin
      tbl = '{'{2'b00, 1'b0, 1'b1, 2'b00}, '{2'b01, 1'b1, 1'b1, 2'b01},
              '{2'b10, 1'b0, 1'b1, 2'b10}, '{2'b11, 1'b1, 1'b1, 2'b01},
              '{2'b11, 1'b0, 1'b1, 2'b10}, '{2'b11, 1'b1, 1'b0, 2'b10},
              '{2'b11, 1'b0, 1'b0, 2'b10}, '{2'b01, 1'b0, 1'b0, 2'b01},
              '{2'b10, 1'b1, 1'b0, 2'b10}, '{2'b00, 1'b1, 1'b0, 2'b00}};
      exp_a = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      exp_b = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
      rst = 1'b1; m_valid = 0; m_reqtyp = 0; s_ready = 0; s_rdata = 0; s_resp = 0;
      for (int j = 0; j < 2; j++) begin
         m_addr[j] = 0; m_wdata[j] = 0; m_size[j] = 0;
      end

      for (int i = 0; i < 10; i++) begin
         p_req = tbl[i].req; p_lg = tbl[i].lg; p_rr = tbl[i].rr;
         #1;
         chk($sformatf("pick vec %0d", i), p_gnt, tbl[i].gnt);
      end

      cyc(); chk_en = 1'b1;
      cyc(); mid();
      chk("reset owner", d_owner[0], 2'b00);
      chk("reset s.valid", d_sval[0], 1'b0);
      chk("reset tmo", d_tmo[0], 1'b0);
      cyc(); rst = 1'b0;

      // m0 read completing on the third grant cycle
      cyc(); m_valid[0] = 1; m_addr[0] = 32'h8000_0000; mid();
      chk("t1 owner idle", d_owner[0], 2'b00);
      cyc(); mid();
      chk("t1 owner gnt0", d_owner[0], 2'b01);
      chk("t1 s.addr", d_saddr[0], 32'h8000_0000);
      cyc(); mid();
      chk("t1 m0 wait", d_mrdy[0], 2'b00);
      cyc(); s_ready = 1; s_rdata = 64'h1122_3344_5566_7788; s_resp = RESP_OKAY; mid();
      chk("t1 m0 ready only", d_mrdy[0], 2'b01);
      chk("t1 m0 rdata", d_mrdata[0][0], 64'h1122_3344_5566_7788);
      chk("t1 m0 resp", d_mresp[0][0], RESP_OKAY);
      cyc(); m_valid[0] = 0; s_ready = 0; s_rdata = 0; mid();
      chk("t1 owner back idle", d_owner[0], 2'b00);

      // both requesting from reset, slave always ready
      cyc(); rst = 1; mid();
      cyc(); rst = 0; m_valid = 2'b11; m_addr[0] = 32'h1000; m_addr[1] = 32'h2000; s_ready = 1; mid();
      for (int k = 0; k < 8; k++) begin
         cyc(); mid();
         chk($sformatf("t2 rr owner %0d", k), d_owner[0], exp_a[k]);
         chk($sformatf("t3 fixed owner %0d", k), d_owner[1], exp_b[k]);
         chk($sformatf("t3 m0 starved %0d", k), d_mrdy[1][0], 1'b0);
      end
      cyc(); m_valid = 0; s_ready = 0;
      cyc(); cyc();

      // m1 double-word write
      cyc(); m_valid[1] = 1; m_reqtyp[1] = 1; m_size[1] = SZ_D; m_addr[1] = 32'h40;
      m_wdata[1] = 64'hDEAD_BEEF_0000_0001; mid();
      cyc(); mid();
      chk("t4 owner", d_owner[0], 2'b10);
      chk("t4 s.reqtyp", d_styp[0], 1'b1);
      chk("t4 s.size", d_ssize[0], SZ_D);
      chk("t4 s.wdata", d_swdata[0], 64'hDEAD_BEEF_0000_0001);
      chk("t4 m1 not ready", d_mrdy[0], 2'b00);
      cyc(); s_ready = 1; mid();
      chk("t4 m1 ready", d_mrdy[0], 2'b10);
      cyc(); m_valid[1] = 0; m_reqtyp[1] = 0; s_ready = 0;
      cyc();

      // watchdog abort on a stalled slave
      cyc(); m_valid[0] = 1; m_addr[0] = 32'h100; s_rdata = 64'h5555_AAAA_5555_AAAA; s_resp = 2'b01; mid();
      for (int k = 1; k <= 15; k++) begin
         cyc(); mid();
         chk($sformatf("t5 wait owner %0d", k), d_owner[0], 2'b01);
         chk($sformatf("t5 wait tmo %0d", k), d_tmo[0], 1'b0);
      end
      cyc(); mid();
      chk("t5 tmo pulse", d_tmo[0], 1'b1);
      chk("t5 m0 ready", d_mrdy[0], 2'b01);
      chk("t5 m0 resp", d_mresp[0][0], RESP_SLVERR);
      chk("t5 m0 rdata", d_mrdata[0][0], 64'h0);
      chk("t5 s.valid abort", d_sval[0], 1'b0);
      cyc(); mid();
      chk("t5 owner idle", d_owner[0], 2'b00);
      chk("t5 s.valid after", d_sval[0], 1'b0);
      cyc(); m_valid[0] = 0; s_rdata = 0; s_resp = 0;
      cyc(); cyc();

      // reset during the second GNT1 cycle
      cyc(); m_valid[1] = 1; mid();
      cyc(); mid();
      chk("t6 owner gnt1", d_owner[0], 2'b10);
      cyc(); rst = 1; mid();
      chk("t6 owner before edge", d_owner[0], 2'b10);
      cyc(); rst = 0; m_valid = 2'b11; mid();
      chk("t6 owner after reset", d_owner[0], 2'b00);
      chk("t6 s.valid after reset", d_sval[0], 1'b0);
      cyc(); mid();
      chk("t6 tie m0 wins", d_owner[0], 2'b01);
      chk("t6 fixed m1 wins", d_owner[1], 2'b10);
      cyc(); m_valid = 0;
      cyc(); cyc();

      // random traffic, stall level varies by phase
      for (int i = 0; i < 3000; i++) begin
         cyc();
         thr = ((i / 150) % 3) * 4;
         rst = ($urandom_range(0, 299) == 0);
         for (int j = 0; j < 2; j++) begin
            if (m_valid[j]) m_valid[j] = ($urandom_range(0, 19) != 0);
            else            m_valid[j] = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
               m_reqtyp[j] = 1'($urandom_range(0, 1));
               m_addr[j]   = $urandom;
               m_wdata[j]  = {$urandom, $urandom};
               m_size[j]   = 2'($urandom_range(0, 3));
            end
         end
         s_ready = ($urandom_range(0, 9) < thr);
         s_rdata = {$urandom, $urandom};
         s_resp  = 2'($urandom_range(0, 3));
      end
      cyc(); rst = 0; m_valid = 0; s_ready = 0;
      cyc(); mid();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
